// File: rtl/cache_lru_state.sv
// Per-set 4-way LRU matrix store with victim selection.
// Two-stage pipeline: S0 issues the array read, S1 picks the way and writes back the updated matrix.
module cache_lru_state #(
  parameter int INDEX_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   init_busy,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [INDEX_WIDTH-1:0] req_index,
  input  logic                   req_hit,
  input  logic [1:0]             req_way,
  output logic                   resp_valid,
  output logic [1:0]             resp_way,
  output logic [INDEX_WIDTH-1:0] resp_index
);

  localparam int LINES = 2 ** INDEX_WIDTH;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t                 state;
  logic [INDEX_WIDTH-1:0] c;

  logic [15:0]            mem [LINES];
  logic [15:0]            rd_data;

  logic                   s1_valid;
  logic [INDEX_WIDTH-1:0] s1_index;
  logic                   s1_hit;
  logic [1:0]             s1_way;
  logic                   use_bypass;
  logic [15:0]            bypass;

  logic                   accept;
  logic [15:0]            cur_matrix;
  logic [2:0]             pop [4];
  logic [2:0]             best;
  logic [1:0]             victim;
  logic [1:0]             sel_way;
  logic [15:0]            new_matrix;

  logic                   mem_we;
  logic [INDEX_WIDTH-1:0] mem_waddr;
  logic [15:0]            mem_wdata;

  assign accept = req_valid & req_ready;

  // A same-index request right behind S1 would read the pre-write value, so it takes the bypass copy.
  always_comb begin
    cur_matrix = use_bypass ? bypass : rd_data;
    for (int r = 0; r < 4; r++) begin
      pop[r] = {2'b00, cur_matrix[4*r]}   + {2'b00, cur_matrix[4*r+1]} +
               {2'b00, cur_matrix[4*r+2]} + {2'b00, cur_matrix[4*r+3]};
    end
    victim = 2'd0;
    best   = pop[0];
    for (int r = 1; r < 4; r++) begin
      if (pop[r] < best) begin
        best   = pop[r];
        victim = 2'(r);
      end
    end
    sel_way = s1_hit ? s1_way : victim;
    new_matrix = cur_matrix;
    for (int r = 0; r < 4; r++) begin
      for (int b = 0; b < 4; b++) begin
        if (r == int'(sel_way)) begin
          new_matrix[4*r+b] = (b != r);
        end else if (b == int'(sel_way)) begin
          new_matrix[4*r+b] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = s1_index;
    mem_wdata = new_matrix;
    if (state == INIT) begin
      mem_we    = 1'b1;
      mem_waddr = c;
      mem_wdata = 16'h0000;
    end else if (s1_valid) begin
      mem_we = 1'b1;
    end
  end

  // The matrix array has no reset; the post-reset sweep clears it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    rd_data <= mem[req_index];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      c          <= '0;
      init_busy  <= 1'b1;
      req_ready  <= 1'b0;
      s1_valid   <= 1'b0;
      s1_index   <= '0;
      s1_hit     <= 1'b0;
      s1_way     <= 2'd0;
      use_bypass <= 1'b0;
      bypass     <= 16'h0000;
      resp_valid <= 1'b0;
      resp_way   <= 2'd0;
      resp_index <= '0;
    end else begin
      unique case (state)
        INIT: begin
          c <= c + 1'b1;
          if (c == INDEX_WIDTH'(LINES - 1)) begin
            state     <= RUN;
            init_busy <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state <= INIT;
        end
      endcase

      s1_valid <= accept;
      if (accept) begin
        s1_index   <= req_index;
        s1_hit     <= req_hit;
        s1_way     <= req_way;
        use_bypass <= s1_valid && (req_index == s1_index);
        bypass     <= new_matrix;
      end

      resp_valid <= s1_valid;
      if (s1_valid) begin
        resp_way   <= sel_way;
        resp_index <= s1_index;
      end
    end
  end

endmodule

// File: tb/tb_cache_lru_state.sv
// Directed scoreboard bench for cache_lru_state: stimulus pushes expected responses,
// a negedge monitor pops and compares way, index and response cycle.
module tb_cache_lru_state;

  logic       clk;
  logic       rst_n;
  logic       init_busy;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_index;
  logic       req_hit;
  logic [1:0] req_way;
  logic       resp_valid;
  logic [1:0] resp_way;
  logic [5:0] resp_index;

  typedef struct {
    logic [1:0] way;
    logic [5:0] idx;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;

  cache_lru_state #(.INDEX_WIDTH(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_busy (init_busy),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_index (req_index),
    .req_hit   (req_hit),
    .req_way   (req_way),
    .resp_valid(resp_valid),
    .resp_way  (resp_way),
    .resp_index(resp_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
  endtask

  // Called just after a rising edge; the request is accepted on the next edge.
  task automatic applyStimulus(input logic [5:0] idx, input logic hit, input logic [1:0] way,
                               input logic [1:0] exp_way);
    exp_t e;
    req_valid = 1'b1;
    req_index = idx;
    req_hit   = hit;
    req_way   = way;
    e.way = exp_way;
    e.idx = idx;
    e.cyc = cyc + 2;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitInit();
    int n = 0;
    while (init_busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    req_valid = 1'b0;
    checkOutput("init_cycles", n, 64);
    checkOutput("ready_after_init", int'(req_ready), 1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("sb_drain", sb.size(), 0);
    sb.delete();
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_resp", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("resp_way", int'(resp_way), int'(e.way));
        checkOutput("resp_index", int'(resp_index), int'(e.idx));
        checkOutput("resp_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_index = '0;
    req_hit   = 1'b0;
    req_way   = 2'd0;
    #12;
    checkOutput("rst_resp_valid", int'(resp_valid), 0);
    checkOutput("rst_resp_way", int'(resp_way), 0);
    checkOutput("rst_resp_index", int'(resp_index), 0);
    checkOutput("rst_init_busy", int'(init_busy), 1);
    checkOutput("rst_req_ready", int'(req_ready), 0);

    // Requests during the sweep must be ignored.
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 1'b1;
    req_index = 6'd5;
    req_hit   = 1'b0;
    waitInit();

    applyStimulus(6'd5, 1'b0, 2'd0, 2'd0);
    idle(2);

    // Spaced misses continue the LRU rotation at index 5.
    applyStimulus(6'd5, 1'b0, 2'd0, 2'd1); idle(1);
    applyStimulus(6'd5, 1'b0, 2'd0, 2'd2); idle(1);
    applyStimulus(6'd5, 1'b0, 2'd0, 2'd3); idle(1);
    applyStimulus(6'd5, 1'b0, 2'd0, 2'd0); idle(1);
    applyStimulus(6'd5, 1'b0, 2'd0, 2'd1); idle(1);

    applyStimulus(6'd9, 1'b1, 2'd3, 2'd3);
    applyStimulus(6'd9, 1'b1, 2'd1, 2'd1);
    applyStimulus(6'd9, 1'b1, 2'd0, 2'd0);
    applyStimulus(6'd9, 1'b1, 2'd2, 2'd2);
    applyStimulus(6'd9, 1'b0, 2'd0, 2'd3);
    idle(2);

    // Back-to-back same-index traffic exercises the bypass.
    applyStimulus(6'd7, 1'b0, 2'd0, 2'd0);
    applyStimulus(6'd7, 1'b0, 2'd0, 2'd1);
    applyStimulus(6'd7, 1'b0, 2'd0, 2'd2);
    applyStimulus(6'd7, 1'b0, 2'd0, 2'd3);
    applyStimulus(6'd7, 1'b1, 2'd1, 2'd1);
    applyStimulus(6'd7, 1'b0, 2'd0, 2'd0);
    idle(2);

    applyStimulus(6'd1, 1'b0, 2'd0, 2'd0);
    applyStimulus(6'd2, 1'b0, 2'd0, 2'd0);
    applyStimulus(6'd1, 1'b0, 2'd0, 2'd1);
    applyStimulus(6'd2, 1'b0, 2'd0, 2'd1);
    applyStimulus(6'd1, 1'b0, 2'd0, 2'd2);
    applyStimulus(6'd3, 1'b0, 2'd0, 2'd0);
    drain();
    idle(2);

    // Reset while a response is on the outputs: it must vanish and the sweep restart.
    req_valid = 1'b1;
    req_index = 6'd5;
    req_hit   = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("pending_resp_valid", int'(resp_valid), 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_resp_valid", int'(resp_valid), 0);
    checkOutput("async_init_busy", int'(init_busy), 1);
    checkOutput("async_req_ready", int'(req_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    waitInit();

    applyStimulus(6'd5, 1'b0, 2'd0, 2'd0);
    drain();
    idle(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
